// File: rtl/mcu_spi_slave.sv
// mcu_spi_slave: SPI mode-0 slave that routes MCU command frames to the
// system-control, HID and SD-card sinks and returns their reply bytes on MISO.
// The first byte of a frame selects the target; later bytes are strobed to it.
// Optional build macro: MCU_SPI_TIMEOUT_EN adds an idle-clock abort
// (timeout_err pulse plus an ABORT state held until ss is released).
module mcu_spi_slave #(
  parameter int unsigned SYNC_STAGES    = 2,
  parameter int unsigned TIMEOUT_CYCLES = 65535
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       spi_io_ss,
  input  logic       spi_io_clk,
  input  logic       spi_io_din,
  output logic       spi_io_dout,
  output logic [7:0] data_in,
  output logic       data_in_start,
  output logic       sys_strobe,
  output logic       hid_strobe,
  output logic       sdc_strobe,
  input  logic [7:0] sys_data_out,
  input  logic [7:0] hid_data_out,
  input  logic [7:0] sdc_data_out,
  output logic       frame_active,
  output logic       timeout_err
);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_TARGET = 3'd1,
    ST_CMD    = 3'd2,
    ST_DATA   = 3'd3
`ifdef MCU_SPI_TIMEOUT_EN
    ,
    ST_ABORT  = 3'd4
`endif
  } state_t;

  typedef enum logic [1:0] {
    TGT_NONE = 2'd0,
    TGT_SYS  = 2'd1,
    TGT_HID  = 2'd2,
    TGT_SDC  = 2'd3
  } target_t;

`ifdef MCU_SPI_TIMEOUT_EN
  localparam int unsigned TO_W = (TIMEOUT_CYCLES > 65535) ? $clog2(TIMEOUT_CYCLES + 1) : 16;
  logic [TO_W-1:0] to_cnt;
`endif

  logic [SYNC_STAGES-1:0] ss_sync;
  logic [SYNC_STAGES-1:0] sclk_sync;
  logic [SYNC_STAGES-1:0] din_sync;
  logic                   ss_prev;
  logic                   sclk_prev;

  state_t     state;
  target_t    target;
  logic [2:0] bit_cnt;
  logic [6:0] shift_rx;
  logic [7:0] tx_shift;
  logic       dout_q;
  logic [7:0] sel_out;

  logic       ss_s;
  logic       sclk_s;
  logic       din_s;
  logic       ss_fall;
  logic       sclk_rise;
  logic       sclk_fall;
  logic [7:0] rx_byte;

  // Maps the frame's first byte onto a sink.
  function automatic target_t decode_target(input logic [7:0] b);
    case (b)
      8'h01:   decode_target = TGT_SYS;
      8'h02:   decode_target = TGT_HID;
      8'h03:   decode_target = TGT_SDC;
      default: decode_target = TGT_NONE;
    endcase
  endfunction

  assign ss_s      = ss_sync[SYNC_STAGES-1];
  assign sclk_s    = sclk_sync[SYNC_STAGES-1];
  assign din_s     = din_sync[SYNC_STAGES-1];
  assign ss_fall   = ss_prev & ~ss_s;
  assign sclk_rise = sclk_s & ~sclk_prev;
  assign sclk_fall = ~sclk_s & sclk_prev;
  assign rx_byte   = {shift_rx, din_s};

  // Reply mux: only a latched target past the target byte drives MISO data.
  always_comb begin
    sel_out = 8'h00;
    if (state == ST_CMD || state == ST_DATA) begin
      case (target)
        TGT_SYS: sel_out = sys_data_out;
        TGT_HID: sel_out = hid_data_out;
        TGT_SDC: sel_out = sdc_data_out;
        default: sel_out = 8'h00;
      endcase
    end
  end

  // MISO: MSB straight from the mux between bytes, shifted bits otherwise.
  always_comb begin
    spi_io_dout = 1'b0;
    if (!ss_s && (state == ST_TARGET || state == ST_CMD || state == ST_DATA)) begin
      spi_io_dout = (bit_cnt == 3'd0) ? sel_out[7] : dout_q;
    end
  end

`ifndef MCU_SPI_TIMEOUT_EN
  // Timeout disabled: the abort pulse never fires.
  assign timeout_err = 1'b0 && (TIMEOUT_CYCLES != 0);
`endif

  // Synchronizers, frame state machine, byte assembly and strobe generation.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ss_sync       <= '0;
      sclk_sync     <= '0;
      din_sync      <= '0;
      ss_prev       <= 1'b0;
      sclk_prev     <= 1'b0;
      state         <= ST_IDLE;
      target        <= TGT_NONE;
      bit_cnt       <= 3'd0;
      shift_rx      <= 7'd0;
      tx_shift      <= 8'h00;
      dout_q        <= 1'b0;
      data_in       <= 8'h00;
      data_in_start <= 1'b0;
      sys_strobe    <= 1'b0;
      hid_strobe    <= 1'b0;
      sdc_strobe    <= 1'b0;
      frame_active  <= 1'b0;
`ifdef MCU_SPI_TIMEOUT_EN
      timeout_err   <= 1'b0;
      to_cnt        <= '0;
`endif
    end else begin
      ss_sync    <= {ss_sync[SYNC_STAGES-2:0], spi_io_ss};
      sclk_sync  <= {sclk_sync[SYNC_STAGES-2:0], spi_io_clk};
      din_sync   <= {din_sync[SYNC_STAGES-2:0], spi_io_din};
      ss_prev    <= ss_s;
      sclk_prev  <= sclk_s;
      sys_strobe <= 1'b0;
      hid_strobe <= 1'b0;
      sdc_strobe <= 1'b0;
`ifdef MCU_SPI_TIMEOUT_EN
      timeout_err <= 1'b0;
`endif

      if (ss_s && state != ST_IDLE) begin
        // Deselect ends the frame; any partial byte is dropped.
        state        <= ST_IDLE;
        frame_active <= 1'b0;
        target       <= TGT_NONE;
        bit_cnt      <= 3'd0;
      end else begin
        case (state)
          ST_IDLE: begin
            // A frame only starts on a fresh ss falling edge.
            if (ss_fall) begin
              state        <= ST_TARGET;
              frame_active <= 1'b1;
              target       <= TGT_NONE;
              bit_cnt      <= 3'd0;
              shift_rx     <= 7'd0;
              tx_shift     <= 8'h00;
              dout_q       <= 1'b0;
`ifdef MCU_SPI_TIMEOUT_EN
              to_cnt       <= '0;
`endif
            end
          end

          ST_TARGET, ST_CMD, ST_DATA: begin
`ifdef MCU_SPI_TIMEOUT_EN
            if (sclk_rise || sclk_fall) begin
              to_cnt <= '0;
            end else if (to_cnt == TO_W'(TIMEOUT_CYCLES - 1)) begin
              timeout_err  <= 1'b1;
              state        <= ST_ABORT;
              frame_active <= 1'b0;
              target       <= TGT_NONE;
              bit_cnt      <= 3'd0;
              to_cnt       <= '0;
            end else begin
              to_cnt <= to_cnt + TO_W'(1);
            end
`endif
            if (sclk_rise) begin
              shift_rx <= rx_byte[6:0];
              bit_cnt  <= bit_cnt + 3'd1;
              if (bit_cnt == 3'd0) begin
                // Bit 7 goes out combinationally; hold it and queue the rest.
                dout_q   <= sel_out[7];
                tx_shift <= {sel_out[6:0], 1'b0};
              end
              if (bit_cnt == 3'd7) begin
                if (state == ST_TARGET) begin
                  target <= decode_target(rx_byte);
                  state  <= ST_CMD;
                end else begin
                  if (target != TGT_NONE) begin
                    data_in       <= rx_byte;
                    data_in_start <= (state == ST_CMD);
                  end
                  sys_strobe <= (target == TGT_SYS);
                  hid_strobe <= (target == TGT_HID);
                  sdc_strobe <= (target == TGT_SDC);
                  state      <= ST_DATA;
                end
              end
            end

            if (sclk_fall && bit_cnt != 3'd0) begin
              dout_q   <= tx_shift[7];
              tx_shift <= {tx_shift[6:0], 1'b0};
            end
          end

          default: begin
            // ABORT: wait for ss to rise (handled above).
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_mcu_spi_slave.sv
// Directed bench for mcu_spi_slave: drives SPI mode-0 frames and checks
// strobes, received bytes, MISO replies, frame tracking and reset/abort cases.
module tb_mcu_spi_slave;

  localparam int HALF = 6;

  logic       clk;
  logic       reset;
  logic       spi_io_ss;
  logic       spi_io_clk;
  logic       spi_io_din;
  logic       spi_io_dout;
  logic [7:0] data_in;
  logic       data_in_start;
  logic       sys_strobe;
  logic       hid_strobe;
  logic       sdc_strobe;
  logic [7:0] sys_data_out;
  logic [7:0] hid_data_out;
  logic [7:0] sdc_data_out;
  logic       frame_active;
  logic       timeout_err;

  int total = 0;
  int bad   = 0;

  logic [10:0] ev_q[$];
  int          to_pulses = 0;
  int          sys_idx   = 0;
  logic [7:0]  sys_reply[2] = '{8'h5C, 8'h42};

  mcu_spi_slave #(
    .SYNC_STAGES   (2),
    .TIMEOUT_CYCLES(100)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .spi_io_ss    (spi_io_ss),
    .spi_io_clk   (spi_io_clk),
    .spi_io_din   (spi_io_din),
    .spi_io_dout  (spi_io_dout),
    .data_in      (data_in),
    .data_in_start(data_in_start),
    .sys_strobe   (sys_strobe),
    .hid_strobe   (hid_strobe),
    .sdc_strobe   (sdc_strobe),
    .sys_data_out (sys_data_out),
    .hid_data_out (hid_data_out),
    .sdc_data_out (sdc_data_out),
    .frame_active (frame_active),
    .timeout_err  (timeout_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Strobe recorder plus a system-control sink that answers each strobe.
  always @(negedge clk) begin
    if (sys_strobe) begin
      ev_q.push_back({2'd1, data_in_start, data_in});
      if (sys_idx < 2) begin
        sys_data_out = sys_reply[sys_idx];
        sys_idx = sys_idx + 1;
      end
    end
    if (hid_strobe) ev_q.push_back({2'd2, data_in_start, data_in});
    if (sdc_strobe) ev_q.push_back({2'd3, data_in_start, data_in});
    if (timeout_err) to_pulses = to_pulses + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total = total + 1;
    assert (obs === exp) else begin
      bad = bad + 1;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_ev(input string tag, input logic [10:0] exp);
    logic [10:0] got;
    got = 11'h7FF;
    if (ev_q.size() != 0) got = ev_q.pop_front();
    chk(tag, 32'(got), 32'(exp));
  endtask

  task automatic spi_bits(input logic [7:0] tx, input int n, output logic [7:0] rx);
    rx = 8'h00;
    for (int i = 0; i < n; i++) begin
      spi_io_din = tx[7-i];
      repeat (HALF) @(negedge clk);
      rx = {rx[6:0], spi_io_dout};
      spi_io_clk = 1'b1;
      repeat (HALF) @(negedge clk);
      spi_io_clk = 1'b0;
    end
  endtask

  task automatic ss_low();
    spi_io_ss = 1'b0;
    repeat (8) @(negedge clk);
  endtask

  task automatic ss_high();
    repeat (HALF) @(negedge clk);
    spi_io_ss = 1'b1;
    repeat (8) @(negedge clk);
  endtask

  initial begin
    logic [7:0] rx;
    reset        = 1'b1;
    spi_io_ss    = 1'b1;
    spi_io_clk   = 1'b0;
    spi_io_din   = 1'b0;
    sys_data_out = 8'h00;
    hid_data_out = 8'h00;
    sdc_data_out = 8'h00;
    repeat (4) @(negedge clk);
    reset = 1'b0;
    repeat (4) @(negedge clk);

    // Reset state
    chk("rst_data_in", 32'(data_in), 32'h00);
    chk("rst_start", 32'(data_in_start), 32'h0);
    chk("rst_strobes", 32'({sys_strobe, hid_strobe, sdc_strobe}), 32'h0);
    chk("rst_dout", 32'(spi_io_dout), 32'h0);
    chk("rst_frame_active", 32'(frame_active), 32'h0);
    chk("rst_timeout", 32'(timeout_err), 32'h0);

    // SYS frame with replies 0x5C then 0x42
    ss_low();
    chk("sys_frame_active", 32'(frame_active), 32'h1);
    spi_bits(8'h01, 8, rx); chk("sys_miso0", 32'(rx), 32'h00);
    spi_bits(8'h00, 8, rx); chk("sys_miso1", 32'(rx), 32'h00);
    spi_bits(8'hAA, 8, rx); chk("sys_miso2", 32'(rx), 32'h5C);
    spi_bits(8'hBB, 8, rx); chk("sys_miso3", 32'(rx), 32'h42);
    ss_high();
    chk("sys_ev_count", 32'(ev_q.size()), 32'd3);
    chk_ev("sys_ev0", {2'd1, 1'b1, 8'h00});
    chk_ev("sys_ev1", {2'd1, 1'b0, 8'hAA});
    chk_ev("sys_ev2", {2'd1, 1'b0, 8'hBB});
    chk("sys_frame_end", 32'(frame_active), 32'h0);
    chk("sys_dout_idle", 32'(spi_io_dout), 32'h0);

    // HID frame, then SDC frame
    ss_low();
    spi_bits(8'h02, 8, rx);
    spi_bits(8'h07, 8, rx);
    ss_high();
    ss_low();
    spi_bits(8'h03, 8, rx);
    spi_bits(8'h05, 8, rx);
    ss_high();
    chk("hs_ev_count", 32'(ev_q.size()), 32'd2);
    chk_ev("hid_ev", {2'd2, 1'b1, 8'h07});
    chk_ev("sdc_ev", {2'd3, 1'b1, 8'h05});
    chk("hold_data_in", 32'(data_in), 32'h05);
    chk("hold_start", 32'(data_in_start), 32'h1);

    // Unknown target 0x7F: no strobes, MISO zero, frame still tracked
    sys_data_out = 8'hFF;
    hid_data_out = 8'hFF;
    sdc_data_out = 8'hFF;
    ss_low();
    for (int b = 0; b < 4; b++) begin
      spi_bits((b == 0) ? 8'h7F : 8'h3C, 8, rx);
      chk($sformatf("none_miso%0d", b), 32'(rx), 32'h00);
      chk($sformatf("none_active%0d", b), 32'(frame_active), 32'h1);
    end
    ss_high();
    chk("none_ev_count", 32'(ev_q.size()), 32'd0);
    chk("none_data_in", 32'(data_in), 32'h05);
    chk("none_frame_end", 32'(frame_active), 32'h0);

    // Deselect after 5 bits of the third byte drops that byte
    ss_low();
    spi_bits(8'h01, 8, rx);
    spi_bits(8'h11, 8, rx);
    spi_bits(8'h33, 5, rx);
    ss_high();
    ss_low();
    spi_bits(8'h01, 8, rx);
    spi_bits(8'h09, 8, rx);
    ss_high();
    chk("part_ev_count", 32'(ev_q.size()), 32'd2);
    chk_ev("part_ev0", {2'd1, 1'b1, 8'h11});
    chk_ev("part_ev1", {2'd1, 1'b1, 8'h09});

    // Reset mid-byte
    ss_low();
    spi_bits(8'h01, 8, rx);
    spi_bits(8'h21, 8, rx);
    spi_bits(8'hF0, 3, rx);
    reset = 1'b1;
    #1;
    chk("mid_rst_data_in", 32'(data_in), 32'h00);
    chk("mid_rst_start", 32'(data_in_start), 32'h0);
    chk("mid_rst_active", 32'(frame_active), 32'h0);
    chk("mid_rst_dout", 32'(spi_io_dout), 32'h0);
    chk("mid_rst_strobes", 32'({sys_strobe, hid_strobe, sdc_strobe}), 32'h0);
    repeat (3) @(negedge clk);
    reset = 1'b0;
    repeat (4) @(negedge clk);
    chk_ev("mid_rst_pre_ev", {2'd1, 1'b1, 8'h21});
    spi_bits(8'h01, 8, rx);
    spi_bits(8'h77, 8, rx);
    chk("no_frame_active", 32'(frame_active), 32'h0);
    chk("no_frame_ev", 32'(ev_q.size()), 32'd0);
    ss_high();
    ss_low();
    spi_bits(8'h02, 8, rx);
    spi_bits(8'h44, 8, rx);
    ss_high();
    chk_ev("post_rst_ev", {2'd2, 1'b1, 8'h44});

    // Idle SPI clock with ss low
    ss_low();
    repeat (150) @(negedge clk);
`ifdef MCU_SPI_TIMEOUT_EN
    chk("to_pulses", 32'(to_pulses), 32'd1);
    chk("to_active", 32'(frame_active), 32'h0);
    spi_bits(8'h01, 8, rx);
    spi_bits(8'h55, 8, rx);
    ss_high();
    chk("to_abort_ev", 32'(ev_q.size()), 32'd0);
`else
    chk("to_pulses", 32'(to_pulses), 32'd0);
    chk("to_active", 32'(frame_active), 32'h1);
    spi_bits(8'h01, 8, rx);
    spi_bits(8'h55, 8, rx);
    ss_high();
    chk_ev("to_cont_ev", {2'd1, 1'b1, 8'h55});
`endif
    ss_low();
    spi_bits(8'h01, 8, rx);
    spi_bits(8'h66, 8, rx);
    ss_high();
    chk_ev("to_after_ev", {2'd1, 1'b1, 8'h66});
    chk("final_ev_count", 32'(ev_q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mcu_spi_slave.md
Name: mcu_spi_slave

Overview:
- SPI mode-0 slave between the MCU SPI pins and the per-target command sinks (system control, HID, SD card).
- Oversamples the SPI signals in the clk domain and assembles bytes.
- The first byte of each frame selects the target. From the second byte on, it issues byte strobes with a start flag to the selected target, and returns that target's reply byte on MISO.

Parameters:
- SYNC_STAGES, 2, synchronizer depth for spi_io_ss/spi_io_clk/spi_io_din (2..3).
- TIMEOUT_CYCLES, 65535, idle-clock abort threshold, only used with MCU_SPI_TIMEOUT_EN.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- spi_io_ss  in  1  chip select, active low
- spi_io_clk  in  1  SPI clock, idle low, sample on rising edge
- spi_io_din  in  1  MOSI
- spi_io_dout  out  1  MISO
- data_in  out  8  last received byte, shared by all targets
- data_in_start  out  1  qualifies a strobe as the first byte after the target byte (command byte)
- sys_strobe  out  1  byte strobe to system control (target 0x01)
- hid_strobe  out  1  byte strobe to HID (target 0x02)
- sdc_strobe  out  1  byte strobe to SD card (target 0x03)
- sys_data_out  in  8  reply byte from system control
- hid_data_out  in  8  reply byte from HID
- sdc_data_out  in  8  reply byte from SD card
- frame_active  out  1  high while a frame is selected
- timeout_err  out  1  one-cycle pulse on frame abort (tied 0 without macro)

Behaviour:
- Clocking and reset:
  - Single clock domain clk.
  - reset is asynchronous, active-high.
  - Reset values: data_in=0x00, data_in_start=0, all strobes=0, spi_io_dout=0, frame_active=0, timeout_err=0, state=IDLE, bit_cnt=0, target=NONE.
  - Reset mid-frame drops the partial byte and the frame. The next frame needs a fresh ss falling edge.
- Synchronization:
  - ss, clk and din pass through SYNC_STAGES flops each.
  - Edges are detected on the synchronized clk.
  - spi_io_clk high and low phases must each be at least 4 clk cycles; faster SPI is unsupported.
- State machine:
  - IDLE: synced ss high. On synced ss low -> TARGET, bit_cnt=0, frame_active=1.
  - TARGET: assemble byte. On completion, latch target: 0x01 SYS, 0x02 HID, 0x03 SDC, anything else NONE. Then -> CMD. No strobe for the target byte.
  - CMD: on byte completion, data_in=byte, data_in_start=1, pulse the strobe of the latched target. Then -> DATA.
  - DATA: each completed byte gives data_in=byte, data_in_start=0, one strobe pulse. Stays in DATA.
  - From any state, synced ss high -> IDLE next cycle. A partial byte is discarded without a strobe. frame_active=0 and target=NONE.
- Byte assembly:
  - On rising synced clk edge: shift_rx={shift_rx[6:0],din}, MSB first, bit_cnt+1 with 3-bit wrap.
  - Completion is the rising edge at bit_cnt==7.
  - The strobe pulses exactly 1 clk cycle, in the cycle after that edge.
  - data_in and data_in_start hold their value until the next strobe.
- MISO path:
  - sel_out = sys/hid/sdc_data_out per latched target; 0x00 for NONE or during TARGET.
  - When bit_cnt==0, spi_io_dout=sel_out[7], combinational from the mux.
  - On the first rising edge of a byte, tx_shift={sel_out[6:0],1'b0}.
  - On each falling synced clk edge with bit_cnt!=0, spi_io_dout=tx_shift[7] and tx_shift shifts left.
  - Targets update data_out within 2 clk cycles after a strobe. The byte replied during byte N is therefore the target's answer to byte N-1.
  - spi_io_dout=0 when ss is high.
- Target NONE: no strobes are issued for the whole frame and MISO reads 0x00. The frame is otherwise tracked normally.

Optional Feature:
- Macro: MCU_SPI_TIMEOUT_EN.
- With it defined:
  - A 16-bit+ counter runs while state!=IDLE and clears on every synced clk edge.
  - When it reaches TIMEOUT_CYCLES: pulse timeout_err for 1 cycle, drop the partial byte, go to an ABORT state with frame_active=0 and no strobes.
  - ABORT returns to IDLE only after synced ss goes high.
- Without it: there is no counter, timeout_err is constant 0, and there is no ABORT state.

Test Plan:
- Frame 0x01,0x00,0xAA,0xBB to SYS -> sys_strobe pulses 3 times with data_in 0x00/0xAA/0xBB and data_in_start 1/0/0; hid_strobe and sdc_strobe stay 0.
- SYS target; sys_data_out set to 0x5C after the first strobe, then 0x42 -> MISO bytes read 0x00,0x00,0x5C,0x42.
- Frame 0x02,0x07 then 0x03,0x05 in a second frame -> one hid_strobe with start=1 and data 0x07, then one sdc_strobe with start=1 and data 0x05.
- Target 0x7F frame of 4 bytes -> zero strobes, MISO all 0x00, frame_active high for the frame duration.
- ss raised after 5 bits of the third byte -> no strobe for it. Next frame 0x01,0x09 -> start=1 strobe with data 0x09.
- Reset asserted mid-byte -> all outputs return to reset values at once. With MCU_SPI_TIMEOUT_EN and TIMEOUT_CYCLES=100, holding clk idle for 100 cycles with ss low gives a timeout_err pulse and no further strobes until ss goes high and low again.
